router_addr_cfg: RTL and testbench

ROUTER_ADDR_CFG -- requirements
Module: router_addr_cfg

---
 rtl/router_cfg_pkg.sv | 28 ++
 rtl/router_addr_cfg.sv | 138 +++++++++++++
 tb/tb_router_addr_cfg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/router_cfg_pkg.sv
// Shared types and constants for the router address configuration block.
package router_cfg_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned FRAME_LEN = 10;  // start + 8 data + parity
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_CHECK  = 2'd3
  } cfg_state_e;

  // Router coordinate: X in the upper nibble, Y in the lower nibble.
  typedef struct packed {
    logic [NIB_W-1:0] x;
    logic [NIB_W-1:0] y;
  } addr_t;

  // True when both coordinates lie inside the mesh.
  function automatic logic addr_in_range(addr_t a, int unsigned max_x, int unsigned max_y);
    return (a.x <= NIB_W'(max_x)) && (a.y <= NIB_W'(max_y));
  endfunction

endpackage

// File: rtl/router_addr_cfg.sv
// Serial configuration receiver that commits a checked router address.
module router_addr_cfg
  import router_cfg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 8'h11,
  parameter int unsigned       MAX_X      = 3,
  parameter int unsigned       MAX_Y      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid_i,
  input  logic              cfg_data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_upd_o,
  output logic              cfg_ack_o,
  output logic              cfg_err_o,
  output logic              busy_o
);

  cfg_state_e        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ADDR_W-1:0] shadow_q, shadow_d;
  logic              parity_q, parity_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              upd_q,    upd_d;
  logic              ack_q,    ack_d;
  logic              err_q,    err_d;
  logic              busy_q,   busy_d;

  logic              frame_ok;

  // Even parity over the shadow plus mesh range check.
  always_comb begin
    frame_ok = ((^shadow_q) == parity_q) &&
               addr_in_range(addr_t'(shadow_q), MAX_X, MAX_Y);
  end

  // Next-state and next-output logic for the frame receiver.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    parity_d = parity_q;
    addr_d   = addr_q;
    upd_d    = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i && cfg_data_i) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end

      ST_SHIFT: begin
        if (!cfg_valid_i) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
          err_d    = 1'b1;
        end else begin
          shadow_d = {shadow_q[ADDR_W-2:0], cfg_data_i};
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (!cfg_valid_i) begin
          state_d  = ST_IDLE;
          shadow_d = '0;
          err_d    = 1'b1;
        end else begin
          parity_d = cfg_data_i;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // Inputs are deliberately ignored here; the next start bit is
        // taken in IDLE on the following cycle.
        state_d = ST_IDLE;
        if (frame_ok) begin
          addr_d = shadow_q;
          upd_d  = 1'b1;
          ack_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      parity_q <= 1'b0;
      addr_q   <= RESET_ADDR;
      upd_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      parity_q <= parity_d;
      addr_q   <= addr_d;
      upd_q    <= upd_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign addr_o     = addr_q;
  assign addr_upd_o = upd_q;
  assign cfg_ack_o  = ack_q;
  assign cfg_err_o  = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_router_addr_cfg.sv
// Testbench for router_addr_cfg: directed scenarios plus random frames.
module tb_router_addr_cfg;

  localparam logic [7:0] RST_ADDR = 8'h11;
  localparam int unsigned MX = 3;
  localparam int unsigned MY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid_i;
  logic       cfg_data_i;
  logic [7:0] addr_o;
  logic       addr_upd_o;
  logic       cfg_ack_o;
  logic       cfg_err_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int ack_cycles[$];

  // Reference model: frame position and collected bits.
  int         m_phase = 0;   // 0 idle, 1..9 next frame bit, 10 checking
  int         m_data  = 0;
  int         m_par   = 0;
  logic [7:0] m_addr  = RST_ADDR;
  logic       m_upd   = 1'b0;
  logic       m_ack   = 1'b0;
  logic       m_err   = 1'b0;

  router_addr_cfg #(
    .RESET_ADDR(RST_ADDR),
    .MAX_X     (MX),
    .MAX_Y     (MY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid_i(cfg_valid_i),
    .cfg_data_i (cfg_data_i),
    .addr_o     (addr_o),
    .addr_upd_o (addr_upd_o),
    .cfg_ack_o  (cfg_ack_o),
    .cfg_err_o  (cfg_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Advance the model by one clock using this cycle's inputs.
  task automatic model_step(input logic r, input logic v, input logic d);
    m_upd = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    if (r) begin
      m_phase = 0;
      m_addr  = RST_ADDR;
    end else if (m_phase == 0) begin
      if (v && d) begin m_phase = 1; m_data = 0; end
    end else if (m_phase <= 9) begin
      if (!v) begin
        m_err = 1'b1; m_phase = 0;
      end else if (m_phase <= 8) begin
        m_data = m_data * 2 + int'(d); m_phase++;
      end else begin
        m_par = int'(d); m_phase = 10;
      end
    end else begin
      if (($countones(m_data) % 2 == m_par) && (m_data / 16 <= MX) && (m_data % 16 <= MY)) begin
        m_addr = 8'(m_data); m_upd = 1'b1; m_ack = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_phase = 0;
    end
  endtask

  // Drive one cycle, then compare every output against the model.
  task automatic step(input logic r, input logic v, input logic d);
    rst = r; cfg_valid_i = v; cfg_data_i = d;
    @(posedge clk);
    #1;
    cycle++;
    model_step(r, v, d);
    if (cfg_ack_o === 1'b1) ack_cycles.push_back(cycle);
    chk("addr_o",     addr_o,             m_addr);
    chk("addr_upd_o", 8'(addr_upd_o),     8'(m_upd));
    chk("cfg_ack_o",  8'(cfg_ack_o),      8'(m_ack));
    chk("cfg_err_o",  8'(cfg_err_o),      8'(m_err));
    chk("busy_o",     8'(busy_o),         8'(m_phase != 0));
    chk("ack_err_excl", 8'(cfg_ack_o & cfg_err_o), 8'h00);
  endtask

  // One frame; abort_at / rst_at pick a frame cycle (1..9) to disturb, 0 = none.
  task automatic send_frame(input logic [7:0] data, input logic par,
                            input int abort_at, input int rst_at);
    logic b;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      if (i == rst_at) begin step(1'b1, 1'b1, 1'b1); return; end
      if (i == abort_at) begin step(1'b0, 1'b0, 1'b0); return; end
      b = (i <= 8) ? data[8-i] : par;
      step(1'b0, 1'b1, b);
    end
    // CHECK cycle: inputs are don't-care.
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [7:0] rd;
    int         ab;
    int         rs;

    rst = 1'b1; cfg_valid_i = 1'b0; cfg_data_i = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_addr", addr_o, 8'h11);
    chk("reset_busy", 8'(busy_o), 8'h00);

    // Good frame 0x23, parity 1.
    send_frame(8'h23, 1'b1, 0, 0);
    chk("good_addr", addr_o, 8'h23);
    chk("good_ack",  8'(cfg_ack_o), 8'h01);
    chk("good_upd",  8'(addr_upd_o), 8'h01);
    step(1'b0, 1'b0, 1'b0);
    chk("good_ack_drop", 8'(cfg_ack_o), 8'h00);

    // Bad parity leaves the reset address in place.
    step(1'b1, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 0, 0);
    chk("par_err",  8'(cfg_err_o), 8'h01);
    chk("par_addr", addr_o, 8'h11);

    // X out of range with correct parity.
    send_frame(8'h42, 1'b0, 0, 0);
    chk("range_err",  8'(cfg_err_o), 8'h01);
    chk("range_addr", addr_o, 8'h11);

    // Abort at frame cycle 5, then reset at frame cycle 6 of a new frame.
    send_frame(8'h22, 1'b0, 5, 0);
    chk("abort_err", 8'(cfg_err_o), 8'h01);
    send_frame(8'h33, 1'b0, 0, 6);
    chk("midrst_addr", addr_o, 8'h11);
    chk("midrst_err",  8'(cfg_err_o), 8'h00);

    // Recommit of an equal value still pulses update.
    send_frame(8'h11, 1'b0, 0, 0);
    chk("same_upd", 8'(addr_upd_o), 8'h01);

    // Back-to-back frames, second start in the ack cycle.
    ack_cycles.delete();
    send_frame(8'h12, 1'b0, 0, 0);
    send_frame(8'h33, 1'b0, 0, 0);
    chk("b2b_addr", addr_o, 8'h33);
    chk("b2b_acks", 8'(ack_cycles.size()), 8'd2);
    if (ack_cycles.size() == 2)
      chk("b2b_spacing", 8'(ack_cycles[1] - ack_cycles[0]), 8'd11);

    // Random frames, aborts, resets and idle noise.
    for (int n = 0; n < 150; n++) begin
      rd = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 9)) : 0;
      rs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 9)) : 0;
      send_frame(rd, 1'($urandom_range(0, 1)), ab, rs);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
